// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
//   hz_state_t : controller FSM state encoding
//   REG_ZERO   : hard-wired zero register number (never a real producer)
package id_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_MDU_BUSY  = 2'd1,
    HZ_EXC_DRAIN = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage sequencing bundle between the pipeline and the hazard controller.
//   master : pipeline side, drives ID/EX/MEM status and exc_req, observes controls
//   slave  : controller side, observes status, drives enables/flushes/mdu_busy/stall_cnt
interface id_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_branch;
  logic             id_mdu_start;
  logic             id_hilo_rd;
  logic             ex_regWrite;
  logic             ex_memRead;
  logic [4:0]       ex_rw;
  logic             mem_memRead;
  logic [4:0]       mem_rw;
  logic             exc_req;
  logic             pc_en;
  logic             ifid_en;
  logic             if_flush;
  logic             id_flush;
  logic             ex_flush;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_mdu_start, id_hilo_rd,
           ex_regWrite, ex_memRead, ex_rw, mem_memRead, mem_rw, exc_req,
    input  pc_en, ifid_en, if_flush, id_flush, ex_flush, mdu_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_mdu_start, id_hilo_rd,
           ex_regWrite, ex_memRead, ex_rw, mem_memRead, mem_rw, exc_req,
    output pc_en, ifid_en, if_flush, id_flush, ex_flush, mdu_busy, stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl_match.sv
// hz_match: does one producer's destination feed a source the ID instruction reads?
//   r             : producer destination register
//   id_rs, id_rt  : ID source registers
//   use_rs,use_rt : ID instruction actually reads rs / rt
//   hit           : dependency found ($0 never matches)
module hz_match
  import id_hazard_ctrl_pkg::*;
(
  input  logic [4:0] r,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       hit
);

  assign hit = (r != REG_ZERO) && ((use_rs && (r == id_rs)) || (use_rt && (r == id_rt)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage sequencing controller.
// Detects load-use, branch-operand and MDU-occupancy hazards, drives PC/IF-ID
// enables and per-stage flushes, sequences the exception flush/redirect and
// counts stalled cycles (saturating).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : id_hazard_ctrl_if slave (ID/EX/MEM status in, enables/flushes out)
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  id_hazard_ctrl_if.slave bus
);

  localparam int unsigned MDU_W = $clog2(MDU_LAT + 1);

  hz_state_t        state;
  logic [MDU_W-1:0] mdu_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic ex_hit, mem_hit;
  logic lu_haz, br_haz, mdu_haz, stall;
  logic mdu_busy, mdu_accept;
  logic pc_en, ifid_en, if_flush, id_flush, ex_flush;

  hz_match u_match_ex (
    .r      (bus.ex_rw),
    .id_rs  (bus.id_rs),
    .id_rt  (bus.id_rt),
    .use_rs (bus.id_use_rs),
    .use_rt (bus.id_use_rt),
    .hit    (ex_hit)
  );

  hz_match u_match_mem (
    .r      (bus.mem_rw),
    .id_rs  (bus.id_rs),
    .id_rt  (bus.id_rt),
    .use_rs (bus.id_use_rs),
    .use_rt (bus.id_use_rt),
    .hit    (mem_hit)
  );

  // MDU occupancy follows the counter so it keeps tracking through an exception drain.
  assign mdu_busy = (mdu_cnt != '0);

  assign lu_haz  = bus.ex_memRead && bus.ex_regWrite && ex_hit;
  assign br_haz  = bus.id_is_branch && ((bus.ex_regWrite && ex_hit) || (bus.mem_memRead && mem_hit));
  assign mdu_haz = mdu_busy && (bus.id_mdu_start || bus.id_hilo_rd);
  assign stall   = lu_haz || br_haz || mdu_haz;

  assign mdu_accept = (state == HZ_RUN) && bus.id_mdu_start && !stall && !bus.exc_req;

  // Pipeline controls: exception beats stall beats normal flow.
  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    if_flush = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    if (bus.exc_req) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else begin
      // Wrong-path fetch issued during the redirect cycle is squashed.
      if (state == HZ_EXC_DRAIN) if_flush = 1'b1;
      if (stall) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        id_flush = 1'b1;
      end
    end
  end

  // FSM, MDU occupancy counter and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HZ_RUN;
      mdu_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);

      // The op already in EX keeps running through an exception.
      if (mdu_accept)    mdu_cnt <= MDU_W'(MDU_LAT);
      else if (mdu_busy) mdu_cnt <= mdu_cnt - MDU_W'(1);

      if (bus.exc_req) begin
        state <= HZ_EXC_DRAIN;
      end else begin
        case (state)
          HZ_RUN:       if (mdu_accept) state <= HZ_MDU_BUSY;
          HZ_MDU_BUSY:  if (mdu_cnt == MDU_W'(1)) state <= HZ_RUN;
          HZ_EXC_DRAIN: state <= (mdu_cnt > MDU_W'(1)) ? HZ_MDU_BUSY : HZ_RUN;
          default:      state <= HZ_RUN;
        endcase
      end
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ifid_en   = ifid_en;
  assign bus.if_flush  = if_flush;
  assign bus.id_flush  = id_flush;
  assign bus.ex_flush  = ex_flush;
  assign bus.mdu_busy  = mdu_busy;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl (MDU_LAT=8, CNT_W=4). Each step pushes the
// expected controls and stall count to a scoreboard queue; the entry is popped
// and compared at the following falling edge.
module tb_id_hazard_ctrl;

  localparam int unsigned MDU_LAT = 8;
  localparam int unsigned CNT_W   = 4;

  // Flag vector order: {pc_en, ifid_en, if_flush, id_flush, ex_flush, mdu_busy}
  localparam logic [5:0] NORM   = 6'b110000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] STALLB = 6'b000101;
  localparam logic [5:0] NORMB  = 6'b110001;
  localparam logic [5:0] EXC    = 6'b111110;
  localparam logic [5:0] EXCB   = 6'b111111;
  localparam logic [5:0] DRAIN  = 6'b111000;

  typedef struct {
    string            tag;
    logic [5:0]       flags;
    logic [CNT_W-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [CNT_W-1:0] exp_sc = '0;

  id_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_in();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.id_is_branch = 1'b0; bus.id_mdu_start = 1'b0; bus.id_hilo_rd = 1'b0;
    bus.ex_regWrite = 1'b0; bus.ex_memRead = 1'b0; bus.ex_rw = 5'd0;
    bus.mem_memRead = 1'b0; bus.mem_rw = 5'd0; bus.exc_req = 1'b0;
  endtask

  // lw $2 in EX, ID add $3,$2,$4
  task automatic set_lu();
    clear_in();
    bus.ex_memRead = 1'b1; bus.ex_regWrite = 1'b1; bus.ex_rw = 5'd2;
    bus.id_rs = 5'd2; bus.id_rt = 5'd4; bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
  endtask

  // Inputs are already driven; check this cycle's outputs, then advance one clock.
  task automatic step(input string tag, input logic [5:0] flags);
    exp_t e;
    exp_t o;
    logic [5:0] got;
    e.tag = tag; e.flags = flags; e.sc = exp_sc;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    got = {bus.pc_en, bus.ifid_en, bus.if_flush, bus.id_flush, bus.ex_flush, bus.mdu_busy};
    chk({o.tag, ".ctl"}, 32'(got), 32'(o.flags));
    chk({o.tag, ".cnt"}, 32'(bus.stall_cnt), 32'(o.sc));
    if (!o.flags[5] && !rst) exp_sc = (exp_sc == '1) ? exp_sc : exp_sc + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #1;
    step("reset", NORM);
    rst = 1'b0;
    step("idle", NORM);

    // Load-use: one stall, then released
    set_lu();
    step("lu_stall", STALL);
    clear_in();
    step("lu_release", NORM);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);

    // Load to $0 consumed from $0: never a hazard
    clear_in();
    bus.ex_memRead = 1'b1; bus.ex_regWrite = 1'b1; bus.ex_rw = 5'd0;
    bus.id_use_rs = 1'b1; bus.id_rs = 5'd0;
    step("zero_a", NORM);
    step("zero_b", NORM);

    // ALU result in EX feeding a non-branch: forwarded, no stall
    clear_in();
    bus.ex_regWrite = 1'b1; bus.ex_rw = 5'd5; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    step("alu_fwd", NORM);

    // beq $5,$6 with lw $6 in MEM, then add $5 in EX
    clear_in();
    bus.id_is_branch = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd6;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    bus.mem_memRead = 1'b1; bus.mem_rw = 5'd6;
    step("br_mem", STALL);
    bus.mem_memRead = 1'b0; bus.mem_rw = 5'd0;
    bus.ex_regWrite = 1'b1; bus.ex_rw = 5'd5;
    step("br_ex", STALL);
    bus.ex_regWrite = 1'b0; bus.ex_rw = 5'd0;
    step("br_go", NORM);

    // mult accepted, then mfhi stalled for exactly MDU_LAT cycles
    clear_in();
    bus.id_mdu_start = 1'b1;
    step("mult_acc", NORM);
    clear_in();
    bus.id_hilo_rd = 1'b1;
    for (int i = 0; i < int'(MDU_LAT); i++) begin
      // A second mult while busy stalls and must not restart the counter
      bus.id_mdu_start = (i == 3);
      bus.id_hilo_rd   = (i != 3);
      step($sformatf("mfhi_wait%0d", i), STALLB);
    end
    bus.id_mdu_start = 1'b0; bus.id_hilo_rd = 1'b1;
    step("mfhi_go", NORM);

    // Exception while a load-use hazard is present, then back-to-back exception
    set_lu();
    bus.exc_req = 1'b1;
    step("exc_lu", EXC);
    clear_in();
    bus.exc_req = 1'b1;
    step("exc_again", EXC);
    clear_in();
    step("drain", DRAIN);
    step("post_drain", NORM);

    // Exception in the middle of MDU occupancy: counter keeps running
    clear_in();
    bus.id_mdu_start = 1'b1;
    step("mult2_acc", NORM);
    clear_in();
    bus.id_hilo_rd = 1'b1;
    step("m2_b1", STALLB);
    step("m2_b2", STALLB);
    bus.exc_req = 1'b1;
    step("m2_exc", EXCB);
    bus.exc_req = 1'b0;
    step("m2_drain", STALLB | 6'b001000);
    for (int i = 5; i <= int'(MDU_LAT); i++) step($sformatf("m2_b%0d", i), STALLB);
    step("m2_go", NORM);

    // Asynchronous reset in the middle of MDU occupancy
    clear_in();
    bus.id_mdu_start = 1'b1;
    step("mult3_acc", NORM);
    clear_in();
    step("m3_b1", NORMB);
    step("m3_b2", NORMB);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.mdu_busy), 32'd0);
    chk("arst_cnt", 32'(bus.stall_cnt), 32'd0);
    exp_sc = '0;
    @(posedge clk);
    #1;
    step("rst_hold", NORM);
    rst = 1'b0;
    step("rst_idle", NORM);

    // Stall-counter saturation: 2^CNT_W + 3 stalled cycles
    set_lu();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step($sformatf("sat%0d", i), STALL);
    clear_in();
    step("sat_hold", NORM);
    chk("sat_value", 32'(bus.stall_cnt), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
